// File: rtl/coord_stream_loader.sv
// Parses an ASCII stream of "x,y" lines into coordinate pairs and writes them
// through a single port into the x/y point memories used by the area search.
module coord_stream_loader #(
    parameter int NUM_ELEMENTS = 496,
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_x,
    output logic [DATA_WIDTH-1:0] wr_y,
    output logic [ADDR_WIDTH-1:0] point_count,
    output logic                  finished,
    output logic                  error
);

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_COMMA = 8'h2c;
    localparam logic [7:0] CH_LF    = 8'h0a;
    localparam logic [7:0] CH_CR    = 8'h0d;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [ADDR_WIDTH-1:0] CAPACITY = ADDR_WIDTH'(NUM_ELEMENTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PARSE_X,
        S_PARSE_Y,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_x;
    logic                  r_seen;
    logic                  r_in_ready;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_x;
    logic [DATA_WIDTH-1:0] r_wr_y;
    logic [ADDR_WIDTH-1:0] r_point_count;
    logic                  r_finished;
    logic                  r_error;

    logic                  w_beat;
    logic                  w_is_digit;
    logic [DATA_WIDTH-1:0] w_digit;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic [DATA_WIDTH-1:0] w_x_next;
    logic [DATA_WIDTH-1:0] w_y;
    logic                  w_seen_next;
    logic                  w_in_y_next;
    logic                  w_commit;
    logic                  w_bad;

    assign w_beat     = in_valid && r_in_ready;
    assign w_is_digit = (in_data >= CH_0) && (in_data <= CH_9);
    assign w_digit    = DATA_WIDTH'(in_data - CH_0);

    // Effect of one accepted byte, followed by the end-of-stream flush when in_last is set.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_acc_next  = r_acc;
        w_x_next    = r_x;
        w_y         = r_acc;
        w_seen_next = r_seen;
        w_in_y_next = (r_state == S_PARSE_Y);
        w_commit    = 1'b0;
        w_bad       = 1'b0;

        if (w_is_digit) begin
            w_acc_next  = (r_acc << 3) + (r_acc << 1) + w_digit;
            w_seen_next = 1'b1;
        end else begin
            case (in_data)
                CH_COMMA: begin
                    if (r_state == S_PARSE_X && r_seen) begin
                        w_x_next    = r_acc;
                        w_acc_next  = '0;
                        w_seen_next = 1'b0;
                        w_in_y_next = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                CH_LF: begin
                    if (r_state == S_PARSE_Y && r_seen) begin
                        w_commit = 1'b1;
                    end else if (r_state == S_PARSE_Y || r_seen) begin
                        w_bad = 1'b1;
                    end
                    w_acc_next  = '0;
                    w_seen_next = 1'b0;
                    w_in_y_next = 1'b0;
                end
                CH_CR, CH_SPACE: begin
                end
                default: w_bad = 1'b1;
            endcase
        end

        if (in_last) begin
            // A y field still being accumulated is a complete record without its newline.
            if (w_in_y_next && w_seen_next) begin
                w_commit = 1'b1;
                w_y      = w_acc_next;
            end else if (w_in_y_next || w_seen_next) begin
                w_bad = 1'b1;
            end
            w_acc_next  = '0;
            w_seen_next = 1'b0;
            w_in_y_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_x           <= '0;
            r_seen        <= 1'b0;
            r_in_ready    <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_x        <= '0;
            r_wr_y        <= '0;
            r_point_count <= '0;
            r_finished    <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_point_count <= '0;
                        r_error       <= 1'b0;
                        r_finished    <= 1'b0;
                        r_acc         <= '0;
                        r_seen        <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_state       <= S_PARSE_X;
                    end else begin
                        r_finished <= 1'b0;
                    end
                end
                S_PARSE_X, S_PARSE_Y: begin
                    if (w_beat) begin
                        r_acc  <= w_acc_next;
                        r_x    <= w_x_next;
                        r_seen <= w_seen_next;
                        if (w_bad) begin
                            r_error <= 1'b1;
                        end
                        if (w_commit) begin
                            if (r_point_count < CAPACITY) begin
                                r_wr_en       <= 1'b1;
                                r_wr_addr     <= r_point_count;
                                r_wr_x        <= w_x_next;
                                r_wr_y        <= w_y;
                                r_point_count <= r_point_count + ADDR_WIDTH'(1);
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                        if (in_last) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= w_in_y_next ? S_PARSE_Y : S_PARSE_X;
                        end
                    end
                end
                S_DONE: begin
                    r_finished <= 1'b1;
                    if (!start) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_x        = r_wr_x;
    assign wr_y        = r_wr_y;
    assign point_count = r_point_count;
    assign finished    = r_finished;
    assign error       = r_error;

endmodule

// File: doc/coord_stream_loader.md
# coord_stream_loader

Front-end stage for the day-9 rectangle search. Accepts the puzzle input as an ASCII byte stream of `x,y` records, one per line, and parses each record into a pair of unsigned DATA_WIDTH-bit integers. Each pair is written through a single write port into the x/y coordinate memories that the downstream area-search engine scans. When the stream ends, the block reports the number of points loaded and raises `finished`, which the system uses to kick the search stage.

## Interface

**Parameters**
- `NUM_ELEMENTS`, 496 — capacity of the coordinate memories, in points.
- `DATA_WIDTH`, 64 — width of each coordinate.
- `ADDR_WIDTH`, 16 — width of the write address and of the point counter.

**Ports**
- `clk` in 1 — single clock; all logic is on the rising edge.
- `rst` in 1 — asynchronous, active-low reset; assertion forces every register to its reset value.
- `start` in 1 — level; begins a load when the block is in IDLE.
- `in_valid` in 1 — a stream byte is present.
- `in_ready` out 1 — the block accepts a byte on any cycle where `in_valid && in_ready`.
- `in_data` in 8 — ASCII byte.
- `in_last` in 1 — qualifies the final byte of the stream.
- `wr_en` out 1 — one-cycle memory write strobe.
- `wr_addr` out ADDR_WIDTH — point index, 0-based.
- `wr_x` out DATA_WIDTH — parsed x value.
- `wr_y` out DATA_WIDTH — parsed y value.
- `point_count` out ADDR_WIDTH — number of points written so far.
- `finished` out 1 — load complete; stays high while `start` is held.
- `error` out 1 — sticky malformed-input / overflow flag.

## Operation

**States**
- IDLE: `in_ready`=0. If `start`=1, clear `point_count`, `error`, `finished`, the accumulator and the digit-seen flag, then go to PARSE_X.
- PARSE_X: `in_ready`=1.
- PARSE_Y: `in_ready`=1.
- DONE: `in_ready`=0; `finished`=1. Return to IDLE when `start`=0.

**Byte rules (accepted beats only)**
- `'0'`–`'9'`: acc = acc·10 + digit, truncated modulo 2^DATA_WIDTH; set the digit-seen flag.
- `','` in PARSE_X with a digit seen: latch acc as x, clear acc and the flag, go to PARSE_Y.
- `','` in PARSE_X with no digit seen, or `','` in PARSE_Y: set `error`; the byte is otherwise ignored.
- `'\n'` in PARSE_Y with a digit seen: commit the point (acc becomes y), then go to PARSE_X.
- `'\n'` in PARSE_X with no digit seen: blank line, ignored.
- `'\n'` in any other case: set `error`, discard the partial record, go to PARSE_X.
- `'\r'` and `' '`: ignored in all parse states.
- Any other byte: set `error`; the byte is ignored.

**Commit**
- If `point_count` < NUM_ELEMENTS: pulse `wr_en` with `wr_addr` = `point_count`, `wr_x`, `wr_y`, and increment `point_count`.
- Otherwise the point is dropped and `error` is set. `point_count` saturates at NUM_ELEMENTS.

**End of stream**
- The beat with `in_last`=1 is processed normally.
- Then, if the block is in PARSE_Y with a digit seen, the point is committed (a trailing newline is optional).
- If a partial record remains (PARSE_X with a digit seen, or PARSE_Y with no digit seen), set `error` and discard it.
- The state then becomes DONE.

- `start` outside IDLE is ignored. `start` held high across DONE→IDLE does not relaunch a load until it has been seen low.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_x`=0, `wr_y`=0, `point_count`=0, `finished`=0, `error`=0; state IDLE.
- `start` sampled at edge N → PARSE_X at N+1; `in_ready`=1 from N+1.
- Throughput is one byte per cycle; `in_ready` never drops during parsing.
- Commit beat accepted at edge N → `wr_en`=1 with valid address/data during cycle N+1 only; `point_count` updated at N+1.
- `in_last` beat at edge N → state DONE and `in_ready`=0 at N+1 (same cycle as any final `wr_en`); `finished`=1 at N+2.
- `error` is registered: it rises the cycle after the offending beat and stays high until the next `start` in IDLE.
- Reset asserted mid-load: all outputs return to reset values immediately; a partial record is lost and memory contents are not touched.

## Test plan
- Stream "7,1\n11,1\n11,7\n" with `in_last` on the final '\n' → 3 `wr_en` pulses at addrs 0, 1, 2 with (7,1), (11,1), (11,7); `point_count`=3; `finished`=1 two cycles after the last beat; `error`=0.
- Stream "3,4" with no newline (`in_last` on '4') → one write (3,4) in the cycle `in_ready` falls; `error`=0.
- "1,2\r\n\n5,6\n" with `in_valid` toggling every other cycle → writes (1,2) and (5,6) only; `error`=0.
- "1,x2\n" → `error`=1; write (1,2) still occurs. Separately, "12\n" → no write, `error`=1.
- NUM_ELEMENTS+2 valid lines → NUM_ELEMENTS writes at addrs 0..NUM_ELEMENTS-1; `point_count`=NUM_ELEMENTS; `error`=1.
- Assert `rst` low after "98765," → all outputs 0, state IDLE. After a new `start`, "2,3\n" writes (2,3) at addr 0.
